mem_sched: RTL



---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_rr_arb2.sv | 89 ++++++++
 rtl/mem_sched.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and arbitration state type for the row/word buffer scheduler.
package mem_pkg;

    localparam int DEF_ROW       = 16;
    localparam int DEF_WIDTH     = 128;
    localparam int DEF_LOG_WIDTH = 7;
    localparam int DEF_WORD      = 16;

    typedef enum logic {
        LAST_RD = 1'b0,
        LAST_WR = 1'b1
    } grant_state_e;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-requester round-robin arbiter (write vs read) for the shared memory port.
// Optional sticky bursts when MEM_SCHED_BURST_EN is defined.
module mem_rr_arb2
    import mem_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic wr_elig_i,
    input  logic rd_elig_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    grant_state_e state_q, state_d;
    logic         keep_owner;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LAST_WR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        gnt_wr_o = 1'b0;
        gnt_rd_o = 1'b0;
        state_d  = state_q;
        if (flush_i) begin
            state_d = LAST_WR;
        end else begin
            if (wr_elig_i && rd_elig_i) begin
                // On a tie the last owner wins only while its burst is still open.
                if (keep_owner == (state_q == LAST_WR)) begin
                    gnt_wr_o = 1'b1;
                end else begin
                    gnt_rd_o = 1'b1;
                end
            end else begin
                gnt_wr_o = wr_elig_i;
                gnt_rd_o = rd_elig_i;
            end
            if (gnt_wr_o) begin
                state_d = LAST_WR;
            end else if (gnt_rd_o) begin
                state_d = LAST_RD;
            end
        end
    end

`ifdef MEM_SCHED_BURST_EN
    localparam int CNT_W = $clog2(BURST + 1);

    logic [CNT_W-1:0] burst_q, burst_d;
    logic             switch_owner;

    assign keep_owner   = (burst_q != '0) && (burst_q < CNT_W'(BURST));
    assign switch_owner = (gnt_wr_o && (state_q == LAST_RD)) ||
                          (gnt_rd_o && (state_q == LAST_WR));

    always_comb begin
        burst_d = burst_q;
        if (flush_i || !(gnt_wr_o || gnt_rd_o)) begin
            burst_d = '0;
        end else if (switch_owner) begin
            burst_d = CNT_W'(1);
        end else if (burst_q < CNT_W'(BURST)) begin
            burst_d = burst_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic unused_burst;

    assign keep_owner   = 1'b0;
    assign unused_burst = (BURST > 0);
`endif

endmodule

// File: rtl/mem_sched.sv
// Single-port scheduler for the row/word buffer: circular FIFO addressing, occupancy
// and fixed-latency read return. Sticky burst grants under MEM_SCHED_BURST_EN.
module mem_sched
    import mem_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LOG_WIDTH = DEF_LOG_WIDTH,
    parameter int WORD      = DEF_WORD,
    parameter int BURST     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WORD-1:0]      wr_data,
    input  logic                 rd_req,
    output logic                 rd_ready,
    output logic                 rd_valid,
    output logic [WORD-1:0]      rd_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [LOG_WIDTH-1:0] mem_addr,
    output logic [WORD-1:0]      mem_wdata,
    input  logic [WORD-1:0]      mem_rdata,
    output logic [LOG_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [LOG_WIDTH:0] CNT_FULL = (LOG_WIDTH + 1)'(WIDTH);

    logic [LOG_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_WIDTH:0]   count_q, count_d;
    logic                 en_q, en_d;
    logic                 we_q, we_d;
    logic [LOG_WIDTH-1:0] addr_q, addr_d;
    logic [WORD-1:0]      wdata_q, wdata_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 gnt_wr, gnt_rd;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    mem_rr_arb2 #(
        .BURST (BURST)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .wr_elig_i (wr_valid && !full),
        .rd_elig_i (rd_req && !empty),
        .gnt_wr_o  (gnt_wr),
        .gnt_rd_o  (gnt_rd)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        en_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        // A read command on the port this cycle returns data on the next one.
        rd_valid_d = en_q && !we_q;
        if (gnt_wr) begin
            en_d     = 1'b1;
            we_d     = 1'b1;
            addr_d   = wr_ptr_q;
            wdata_d  = wr_data;
            wr_ptr_d = wr_ptr_q + LOG_WIDTH'(1);
            count_d  = count_q + (LOG_WIDTH + 1)'(1);
        end else if (gnt_rd) begin
            en_d     = 1'b1;
            addr_d   = rd_ptr_q;
            rd_ptr_d = rd_ptr_q + LOG_WIDTH'(1);
            count_d  = count_q - (LOG_WIDTH + 1)'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign wr_ready  = gnt_wr;
    assign rd_ready  = gnt_rd;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = mem_rdata;
    assign mem_en    = en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;

endmodule
